generador_tono: RTL and testbench

Tone generator that sits directly downstream of the free-play note FSM. It consumes the 3-bit note code and the `contar` enable and drives a square-wave `audio` output to the buzzer at the pitch of the selected note. It also measures how long each note is held, in milliseconds, and reports each finished note with a one-cycle pulse for scoring and display logic.

---
 rtl/generador_tono.sv | 112 +++++++++++
 tb/tb_generador_tono.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/generador_tono.sv
// Square-wave tone generator for the free-play note FSM. It also times each held note
// in milliseconds and pulses fin_nota when a note ends.
module generador_tono #(
    parameter int MS_DIV = 50000,
    parameter int DIV1   = 95420,
    parameter int DIV2   = 85034,
    parameter int DIV3   = 75758,
    parameter int DIV4   = 71633,
    parameter int DUR_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       nota,
    input  logic             contar,
    output logic             audio,
    output logic             sonando,
    output logic [DUR_W-1:0] duracion_ms,
    output logic             fin_nota,
    output logic [2:0]       nota_fin
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam int DIV_M12 = (DIV1 > DIV2) ? DIV1 : DIV2;
    localparam int DIV_M34 = (DIV3 > DIV4) ? DIV3 : DIV4;
    localparam int DIV_MAX = (DIV_M12 > DIV_M34) ? DIV_M12 : DIV_M34;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);
    localparam int MS_W    = $clog2(MS_DIV + 1);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [2:0]       cur_nota;
    logic [DIV_W-1:0] div_cnt;
    logic [MS_W-1:0]  ms_pre;
    logic             activo;

    assign activo = contar && (nota >= 3'd1) && (nota <= 3'd4);

    // Terminal count of the half-period divider for a given note code
    function automatic logic [DIV_W-1:0] div_last(input logic [2:0] n);
        case (n)
            3'd2:    div_last = DIV_W'(DIV2 - 1);
            3'd3:    div_last = DIV_W'(DIV3 - 1);
            3'd4:    div_last = DIV_W'(DIV4 - 1);
            default: div_last = DIV_W'(DIV1 - 1);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            audio       <= 1'b0;
            sonando     <= 1'b0;
            fin_nota    <= 1'b0;
            nota_fin    <= 3'd0;
            duracion_ms <= '0;
            cur_nota    <= 3'd0;
            div_cnt     <= '0;
            ms_pre      <= '0;
        end else begin
            fin_nota <= 1'b0;
            case (state)
                IDLE: begin
                    audio <= 1'b0;
                    if (activo) begin
                        state       <= PLAY;
                        cur_nota    <= nota;
                        div_cnt     <= '0;
                        ms_pre      <= '0;
                        duracion_ms <= '0;
                        sonando     <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!activo) begin
                        state    <= IDLE;
                        sonando  <= 1'b0;
                        audio    <= 1'b0;
                        fin_nota <= 1'b1;
                        nota_fin <= cur_nota;
                    end else if (nota != cur_nota) begin
                        // Legato: report the old note and restart timing for the new one
                        fin_nota    <= 1'b1;
                        nota_fin    <= cur_nota;
                        cur_nota    <= nota;
                        div_cnt     <= '0;
                        ms_pre      <= '0;
                        duracion_ms <= '0;
                        audio       <= 1'b0;
                    end else begin
                        if (div_cnt == div_last(cur_nota)) begin
                            div_cnt <= '0;
                            audio   <= ~audio;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                        if (ms_pre == MS_W'(MS_DIV - 1)) begin
                            ms_pre <= '0;
                            if (duracion_ms != DUR_MAX)
                                duracion_ms <= duracion_ms + DUR_ONE;
                        end else begin
                            ms_pre <= ms_pre + MS_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_generador_tono.sv
// Directed bench for generador_tono: a table of {inputs held N cycles, expected outputs}
// rows plus hand-written saturation and mid-note reset sequences.
module tb_generador_tono;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] nota;
    logic       contar;
    logic       audio;
    logic       sonando;
    logic [3:0] duracion_ms;
    logic       fin_nota;
    logic [2:0] nota_fin;

    int checks = 0;
    int errors = 0;

    generador_tono #(
        .MS_DIV(10), .DIV1(4), .DIV2(5), .DIV3(6), .DIV4(7), .DUR_W(4)
    ) dut (
        .clk(clk), .reset(reset), .nota(nota), .contar(contar),
        .audio(audio), .sonando(sonando), .duracion_ms(duracion_ms),
        .fin_nota(fin_nota), .nota_fin(nota_fin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       con;
        logic [2:0] nt;
        int         n;
        logic       aud;
        logic       son;
        logic [3:0] dur;
        logic       fin;
        logic [2:0] nf;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic con, input logic [2:0] nt, input int n,
                                input logic aud, input logic son, input logic [3:0] dur,
                                input logic fin, input logic [2:0] nf, input string name);
        vec_t v;
        v.rst = rst; v.con = con; v.nt = nt; v.n = n;
        v.aud = aud; v.son = son; v.dur = dur; v.fin = fin; v.nf = nf; v.name = name;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic [2:0] n);
        @(negedge clk);
        reset = r; contar = c; nota = n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " audio"}, 16'(audio), 16'd0);
        chk({nm, " sonando"}, 16'(sonando), 16'd0);
        chk({nm, " dur"}, 16'(duracion_ms), 16'd0);
        chk({nm, " fin"}, 16'(fin_nota), 16'd0);
        chk({nm, " nota_fin"}, 16'(nota_fin), 16'd0);
    endtask

    initial begin
        reset = 1'b1; contar = 1'b1; nota = 3'd1;

        //   rst con nota  n  aud son dur fin nf   name
        add(1, 1, 3'd1,  3, 0, 0, 0, 0, 0, "reset");
        add(0, 1, 3'd1,  1, 0, 1, 0, 0, 0, "tone_enter");
        add(0, 1, 3'd1,  3, 0, 1, 0, 0, 0, "tone_c4");
        add(0, 1, 3'd1,  1, 1, 1, 0, 0, 0, "tone_c5_rise");
        add(0, 1, 3'd1,  4, 0, 1, 0, 0, 0, "tone_c9");
        add(0, 1, 3'd1,  1, 0, 1, 0, 0, 0, "tone_c10");
        add(0, 1, 3'd1,  1, 0, 1, 1, 0, 0, "tone_c11_ms1");
        add(0, 1, 3'd1,  2, 1, 1, 1, 0, 0, "tone_c13");
        add(0, 1, 3'd1,  7, 0, 1, 1, 0, 0, "tone_c20");
        add(0, 1, 3'd1,  1, 1, 1, 2, 0, 0, "tone_c21_ms2");
        add(0, 1, 3'd1, 19, 1, 1, 3, 0, 0, "tone_c40");
        add(0, 0, 3'd1,  1, 0, 0, 3, 1, 1, "tone_release");
        add(0, 0, 3'd1,  1, 0, 0, 3, 0, 1, "tone_idle");
        add(0, 1, 3'd3,  1, 0, 1, 0, 0, 1, "e4_enter");
        add(0, 1, 3'd3, 24, 0, 1, 2, 0, 1, "e4_c25");
        add(0, 0, 3'd3,  1, 0, 0, 2, 1, 3, "e4_release");
        add(0, 0, 3'd3,  1, 0, 0, 2, 0, 3, "e4_pulse_end");
        add(0, 0, 3'd3,  5, 0, 0, 2, 0, 3, "e4_hold");
        add(0, 1, 3'd2,  1, 0, 1, 0, 0, 3, "d4_enter");
        add(0, 1, 3'd2, 11, 0, 1, 1, 0, 3, "d4_c12");
        add(0, 1, 3'd4,  1, 0, 1, 0, 1, 2, "legato");
        add(0, 1, 3'd4,  1, 0, 1, 0, 0, 2, "f4_j1");
        add(0, 1, 3'd4,  5, 0, 1, 0, 0, 2, "f4_j6");
        add(0, 1, 3'd4,  1, 1, 1, 0, 0, 2, "f4_j7_rise");
        add(0, 1, 3'd4,  6, 1, 1, 1, 0, 2, "f4_j13");
        add(0, 1, 3'd4,  1, 0, 1, 1, 0, 2, "f4_j14_fall");
        add(0, 0, 3'd4,  1, 0, 0, 1, 1, 4, "f4_release");
        add(0, 1, 3'd1,  1, 0, 1, 0, 0, 4, "reenter");
        add(0, 0, 3'd1,  1, 0, 0, 0, 1, 1, "reenter_release");
        add(0, 0, 3'd1,  1, 0, 0, 0, 0, 1, "reenter_idle");
        add(0, 1, 3'd0,  2, 0, 0, 0, 0, 1, "code0");
        add(0, 1, 3'd5,  2, 0, 0, 0, 0, 1, "code5");
        add(0, 1, 3'd7,  2, 0, 0, 0, 0, 1, "code7");
        add(0, 1, 3'd6,  1, 0, 0, 0, 0, 1, "code6");

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                cycle(tbl[i].rst, tbl[i].con, tbl[i].nt);
                chk({tbl[i].name, " sonando"}, 16'(sonando), 16'(tbl[i].son));
                chk({tbl[i].name, " fin"}, 16'(fin_nota), 16'(tbl[i].fin));
                if (c == tbl[i].n - 1 || tbl[i].rst) begin
                    chk({tbl[i].name, " audio"}, 16'(audio), 16'(tbl[i].aud));
                    chk({tbl[i].name, " dur"}, 16'(duracion_ms), 16'(tbl[i].dur));
                    chk({tbl[i].name, " nota_fin"}, 16'(nota_fin), 16'(tbl[i].nf));
                end
            end
        end

        // Long C4 note: duration climbs to 15 and saturates there
        for (int k = 1; k <= 200; k++) begin
            cycle(1'b0, 1'b1, 3'd1);
            chk("sat fin", 16'(fin_nota), 16'd0);
            if (k == 150) chk("sat c150", 16'(duracion_ms), 16'd14);
            if (k == 151) chk("sat c151", 16'(duracion_ms), 16'd15);
            if (k == 200) chk("sat c200", 16'(duracion_ms), 16'd15);
        end
        chk("sat sonando", 16'(sonando), 16'd1);

        // Reset mid-note: everything clears and the note is never reported
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 3'd1);
            chk_all_zero("midreset");
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 3'd1);
            chk_all_zero("post_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
